// File: rtl/barrier_pkg.sv
// Shared definitions for the eight-way barrier controller.
//   N_WAY   : number of requesters served by one barrier
//   state_t : controller state encoding (2 bits), exported on the debug port
package barrier_pkg;

  localparam int N_WAY = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GATHER  = 2'd1,
    S_RELEASE = 2'd2,
    S_ERROR   = 2'd3
  } state_t;

endpackage

// File: rtl/barrier_sync8_if.sv
// Bus between the worker units and the barrier controller.
//   mask            participant enables (workers -> barrier)
//   arrive          per-requester arrival pulses (workers -> barrier)
//   timeout_lim     gather cycle budget, 0 disables the timeout (workers -> barrier)
//   barrier_release 1-cycle completion pulse (barrier -> workers); the name avoids
//                   the reserved word 'release'
//   arrived         sticky arrival flags of the current generation
//   busy            high in GATHER, RELEASE and ERROR
//   timeout_err     1-cycle pulse on entry to ERROR
//   gen             completed-barrier count (wraps)
//   state           controller state, for debug and checkers
//
// Handshake: there is no valid/ready pair. arrive is sampled on every rising
// edge; a set bit counts as one arrival and repeats on an already-set flag are
// harmless. barrier_release is the only completion indication and lasts exactly
// one cycle; requesters must not arrive again until they have seen it.
interface barrier_sync8_if #(
  parameter int TIMEOUT_W = 8,
  parameter int GEN_W     = 4
);
  import barrier_pkg::*;

  logic [N_WAY-1:0]     mask;
  logic [N_WAY-1:0]     arrive;
  logic [TIMEOUT_W-1:0] timeout_lim;
  logic                 barrier_release;
  logic [N_WAY-1:0]     arrived;
  logic                 busy;
  logic                 timeout_err;
  logic [GEN_W-1:0]     gen;
  state_t               state;

  modport master (
    output mask, arrive, timeout_lim,
    input  barrier_release, arrived, busy, timeout_err, gen, state
  );

  modport slave (
    input  mask, arrive, timeout_lim,
    output barrier_release, arrived, busy, timeout_err, gen, state
  );

endinterface

// File: rtl/barrier_sync8_and8way.sv
// Eight-input AND reduction used to detect barrier completion.
//   a : participant-complete vector (bit set = arrived or not participating)
//   y : 1 when every bit of a is set
module barrier_sync8_and8way
  import barrier_pkg::*;
(
  input  logic [N_WAY-1:0] a,
  output logic             y
);

  assign y = &a;

endmodule

// File: rtl/barrier_sync8.sv
// Eight-way barrier controller. Requesters selected by mask pulse arrive; when
// all of them have arrived the block issues a one-cycle release and bumps the
// generation counter. A programmable timer flags a barrier that stalls in GATHER.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous abort to IDLE (gen is kept)
//   bus   : barrier_sync8_if slave modport (mask/arrive/timeout_lim in,
//           barrier_release/arrived/busy/timeout_err/gen/state out)
// All outputs come from registers or are decoded from the state register only.
module barrier_sync8
  import barrier_pkg::*;
#(
  parameter int TIMEOUT_W = 8,
  parameter int GEN_W     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  barrier_sync8_if.slave  bus
);

  state_t               state_q, state_d;
  logic [N_WAY-1:0]     arrived_q, arrived_d;
  logic [N_WAY-1:0]     mask_q, mask_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic [GEN_W-1:0]     gen_q, gen_d;
  logic                 err_q, err_d;

  logic [N_WAY-1:0]     mask_src;
  logic [N_WAY-1:0]     hit;
  logic [N_WAY-1:0]     nxt;
  logic                 done;

  // The live mask only matters while IDLE; once a generation has started the
  // captured copy is used so mask changes wait for the next generation.
  assign mask_src = (state_q == S_IDLE) ? bus.mask : mask_q;
  assign hit      = bus.arrive & mask_src;
  assign nxt      = arrived_q | hit;

  // Non-participants count as already arrived.
  barrier_sync8_and8way u_done (
    .a (nxt | ~mask_src),
    .y (done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      arrived_q <= '0;
      mask_q    <= '0;
      timer_q   <= '0;
      gen_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      arrived_q <= arrived_d;
      mask_q    <= mask_d;
      timer_q   <= timer_d;
      gen_q     <= gen_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    arrived_d = arrived_q;
    mask_d    = mask_q;
    timer_d   = timer_q;
    gen_d     = gen_q;
    err_d     = 1'b0;

    if (clr) begin
      state_d   = S_IDLE;
      arrived_d = '0;
      mask_d    = '0;
      timer_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A generation starts only on an arrival from a participant.
          if (|hit) begin
            mask_d    = bus.mask;
            arrived_d = nxt;
            if (done) begin
              state_d = S_RELEASE;
            end else begin
              state_d = S_GATHER;
              timer_d = '0;
            end
          end
        end
        S_GATHER: begin
          arrived_d = nxt;
          // Completion is checked before the timeout so a last arrival that
          // lands on the limit cycle still releases.
          if (done) begin
            state_d = S_RELEASE;
          end else if ((bus.timeout_lim != '0) && (timer_q == bus.timeout_lim)) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else if (timer_q != '1) begin
            timer_d = timer_q + TIMEOUT_W'(1);
          end
        end
        S_RELEASE: begin
          // Arrivals seen here are dropped along with the finished generation.
          gen_d     = gen_q + GEN_W'(1);
          arrived_d = '0;
          state_d   = S_IDLE;
        end
        S_ERROR: begin
          // Parked with arrived frozen until clr or reset.
          state_d = S_ERROR;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.barrier_release = (state_q == S_RELEASE);
  assign bus.busy            = (state_q != S_IDLE);
  assign bus.timeout_err     = err_q;
  assign bus.arrived         = arrived_q;
  assign bus.gen             = gen_q;
  assign bus.state           = state_q;

endmodule

// File: tb/tb_barrier_sync8.sv
module tb_barrier_sync8;

  logic clk;
  logic rst_n;
  logic clr;

  barrier_sync8_if #(.TIMEOUT_W(8), .GEN_W(4)) bus ();

  barrier_sync8 #(.TIMEOUT_W(8), .GEN_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vectors ----------------
  // observed tuple: {release, arrived[7:0], busy, timeout_err, gen[3:0]}
  typedef struct {
    logic       clr;
    logic [7:0] mask;
    logic [7:0] arrive;
    logic [7:0] lim;
    logic [14:0] exp;
  } vec_t;

  vec_t vt[$];

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_q[$];

  task automatic add_v(input logic c, input logic [7:0] m, input logic [7:0] a,
                       input logic [7:0] l, input logic rel, input logic [7:0] arr,
                       input logic bsy, input logic err, input logic [3:0] g);
    vec_t v;
    v.clr = c; v.mask = m; v.arrive = a; v.lim = l;
    v.exp = {rel, arr, bsy, err, g};
    vt.push_back(v);
  endtask

  function automatic logic [14:0] observed();
    return {bus.barrier_release, bus.arrived, bus.busy, bus.timeout_err, bus.gen};
  endfunction

  task automatic chk(input string nm, input logic [14:0] act, input logic [14:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got rel=%b arr=%h busy=%b err=%b gen=%0d want rel=%b arr=%h busy=%b err=%b gen=%0d",
               nm, act[14], act[13:6], act[5], act[4], act[3:0],
               exp[14], exp[13:6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic chk1(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic [7:0] m, input logic [7:0] a,
                       input logic [7:0] l);
    clr = c; bus.mask = m; bus.arrive = a; bus.timeout_lim = l;
  endtask

  initial begin
    // ---------------- reset ----------------
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("reset", observed(), {1'b0, 8'h00, 1'b0, 1'b0, 4'd0});
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // -------- table: inputs before the edge, outputs after it --------
    //     clr  mask   arrive lim    rel   arrived busy  err   gen
    // 1: all eight, one per cycle
    add_v(0, 8'hFF, 8'h01, 8'd0,  0, 8'h01, 1, 0, 4'd0);
    add_v(0, 8'hFF, 8'h02, 8'd0,  0, 8'h03, 1, 0, 4'd0);
    add_v(0, 8'hFF, 8'h04, 8'd0,  0, 8'h07, 1, 0, 4'd0);
    add_v(0, 8'hFF, 8'h08, 8'd0,  0, 8'h0F, 1, 0, 4'd0);
    add_v(0, 8'hFF, 8'h10, 8'd0,  0, 8'h1F, 1, 0, 4'd0);
    add_v(0, 8'hFF, 8'h20, 8'd0,  0, 8'h3F, 1, 0, 4'd0);
    add_v(0, 8'hFF, 8'h40, 8'd0,  0, 8'h7F, 1, 0, 4'd0);
    add_v(0, 8'hFF, 8'h80, 8'd0,  1, 8'hFF, 1, 0, 4'd0);
    add_v(0, 8'hFF, 8'h00, 8'd0,  0, 8'h00, 0, 0, 4'd1);
    // 2: simultaneous, then an arrival during RELEASE is dropped
    add_v(0, 8'hFF, 8'hFF, 8'd0,  1, 8'hFF, 1, 0, 4'd1);
    add_v(0, 8'hFF, 8'hFF, 8'd0,  0, 8'h00, 0, 0, 4'd2);
    add_v(0, 8'hFF, 8'h00, 8'd0,  0, 8'h00, 0, 0, 4'd2);
    // unmasked / empty-mask arrivals in IDLE are ignored
    add_v(0, 8'h05, 8'h02, 8'd0,  0, 8'h00, 0, 0, 4'd2);
    add_v(0, 8'h00, 8'hFF, 8'd0,  0, 8'h00, 0, 0, 4'd2);
    // 3: partial mask 05; FA ignored even with live mask widened; repeat 01 harmless
    add_v(0, 8'h05, 8'h01, 8'd0,  0, 8'h01, 1, 0, 4'd2);
    add_v(0, 8'hFF, 8'hFA, 8'd0,  0, 8'h01, 1, 0, 4'd2);
    add_v(0, 8'h05, 8'h01, 8'd0,  0, 8'h01, 1, 0, 4'd2);
    add_v(0, 8'h05, 8'h04, 8'd0,  1, 8'h05, 1, 0, 4'd2);
    add_v(0, 8'h05, 8'h00, 8'd0,  0, 8'h00, 0, 0, 4'd3);
    // 4: timeout lim=3: four GATHER cycles then ERROR, arrive ignored, clr
    add_v(0, 8'hFF, 8'h7F, 8'd3,  0, 8'h7F, 1, 0, 4'd3);
    add_v(0, 8'hFF, 8'h00, 8'd3,  0, 8'h7F, 1, 0, 4'd3);
    add_v(0, 8'hFF, 8'h00, 8'd3,  0, 8'h7F, 1, 0, 4'd3);
    add_v(0, 8'hFF, 8'h00, 8'd3,  0, 8'h7F, 1, 0, 4'd3);
    add_v(0, 8'hFF, 8'h00, 8'd3,  0, 8'h7F, 1, 1, 4'd3);
    add_v(0, 8'hFF, 8'h80, 8'd3,  0, 8'h7F, 1, 0, 4'd3);
    add_v(0, 8'hFF, 8'h00, 8'd3,  0, 8'h7F, 1, 0, 4'd3);
    add_v(1, 8'hFF, 8'h00, 8'd3,  0, 8'h00, 0, 0, 4'd3);
    // 5: tie, lim=2, last arrival on the timer==2 cycle
    add_v(0, 8'h03, 8'h01, 8'd2,  0, 8'h01, 1, 0, 4'd3);
    add_v(0, 8'h03, 8'h00, 8'd2,  0, 8'h01, 1, 0, 4'd3);
    add_v(0, 8'h03, 8'h00, 8'd2,  0, 8'h01, 1, 0, 4'd3);
    add_v(0, 8'h03, 8'h02, 8'd2,  1, 8'h03, 1, 0, 4'd3);
    add_v(0, 8'h03, 8'h00, 8'd2,  0, 8'h00, 0, 0, 4'd4);

    foreach (vt[i]) begin
      drive(vt[i].clr, vt[i].mask, vt[i].arrive, vt[i].lim);
      step();
      chk($sformatf("vec%0d", i), observed(), vt[i].exp);
    end
    drive(1'b0, 8'h00, 8'h00, 8'd0);
    step();

    // -------- 6a: 16 simultaneous barriers, gen passes 15 -> 0 --------
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 8'hFF, 8'hFF, 8'd0);
      step();
      chk1($sformatf("wrap_rel%0d", k), {7'd0, bus.barrier_release}, 8'd1);
      exp_q.push_back(4'((4 + k + 1) % 16));
      drive(1'b0, 8'hFF, 8'h00, 8'd0);
      step();
      chk1($sformatf("wrap_gen%0d", k), {4'd0, bus.gen}, {4'd0, exp_q.pop_front()});
    end

    // -------- 6b: async reset in the middle of GATHER --------
    drive(1'b0, 8'h03, 8'h01, 8'd0);
    step();
    chk1("pre_rst_arrived", bus.arrived, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", observed(), {1'b0, 8'h00, 1'b0, 1'b0, 4'd0});
    drive(1'b0, 8'h03, 8'h00, 8'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    // the other participant arrives: with flags cleared this is a fresh start
    bus.arrive = 8'h02;
    step();
    chk("post_rst_start", observed(), {1'b0, 8'h02, 1'b1, 1'b0, 4'd0});
    bus.arrive = 8'h00;
    for (int k = 0; k < 3; k++) begin
      step();
      chk1($sformatf("post_rst_norel%0d", k), {7'd0, bus.barrier_release}, 8'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
